// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit bus: imem read port and decoder-facing signals
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       inst;
  logic              inst_valid;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              step;
  logic              branch;
  logic              branch_taken;
  logic              jal_flag;
  logic              jalr_flag;
  logic              ecall_flag;
  logic [31:0]       imm;
  logic [31:0]       rs1_data;
  logic              resume;
  logic              halted;
  logic              misaligned;

  modport master (
    output imem_addr, inst, inst_valid, pc, pc_plus4, halted, misaligned,
    input  imem_rdata, step, branch, branch_taken, jal_flag, jalr_flag,
           ecall_flag, imm, rs1_data, resume
  );

  modport slave (
    input  imem_addr, inst, inst_valid, pc, pc_plus4, halted, misaligned,
    output imem_rdata, step, branch, branch_taken, jal_flag, jalr_flag,
           ecall_flag, imm, rs1_data, resume
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC holder, imem fetch sequencer and next-PC select
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LATENCY = 1,
  parameter int          ADDR_W       = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  instruction_fetch_unit_if.master      bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  LAT = IMEM_LATENCY[1:0];

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_VALID, S_HALT} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] target;
  logic        valid_q;
  logic        halted_q;
  logic        mis_q;

  assign bus.imem_addr  = pc_q[ADDR_W+1:2];
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + 32'd4;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.halted     = halted_q;
  assign bus.misaligned = mis_q;

  // ecall is resolved in the FSM; this only covers the jump/branch/sequential targets
  always_comb begin
    target = pc_q + 32'd4;
    if (bus.jalr_flag)
      target = (bus.rs1_data + bus.imm) & 32'hFFFF_FFFE;
    else if (bus.jal_flag || (bus.branch && bus.branch_taken))
      target = pc_q + bus.imm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      pc_q     <= RESET_PC;
      inst_q   <= NOP;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      case (state)
        S_RESET: begin
          cnt   <= 2'd0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (cnt == LAT) begin
            inst_q  <= bus.imem_rdata;
            valid_q <= 1'b1;
            cnt     <= 2'd0;
            state   <= S_VALID;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_VALID: begin
          if (bus.step) begin
            valid_q <= 1'b0;
            inst_q  <= NOP;
            if (bus.ecall_flag) begin
              pc_q     <= pc_q + 32'd4;
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else if (target[1:0] != 2'b00) begin
              // PC stays on the faulting instruction so it can be inspected
              mis_q    <= 1'b1;
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc_q  <= target;
              cnt   <= 2'd0;
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (bus.resume && !mis_q) begin
            halted_q <= 1'b0;
            cnt      <= 2'd0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end
endmodule
